// File: rtl/upstream_pkg.sv
// Shared widths, FSM encoding and arithmetic helpers for the upstream order processor.
package upstream_pkg;

    localparam int CLIENT_W  = 5;
    localparam int AMOUNT_W  = 16;
    localparam int MAX_W     = 32;
    localparam int N_CLIENTS = 1 << CLIENT_W;

    typedef enum logic [1:0] {IDLE, READ, CHECK, COMMIT} up_state_t;

    // Per-client totals clamp at all-ones instead of wrapping.
    function automatic logic [AMOUNT_W-1:0] sat16(input logic [AMOUNT_W-1:0] a,
                                                  input logic [AMOUNT_W-1:0] b);
        logic [AMOUNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[AMOUNT_W] ? {AMOUNT_W{1'b1}} : s[AMOUNT_W-1:0];
    endfunction

endpackage

// File: rtl/upstream_order_processor_if.sv
// Upstream order bus: front end (master) drives requests, order processor (slave) responds.
interface upstream_order_processor_if;
    import upstream_pkg::*;

    logic                new_order;
    logic                new_max;
    logic [CLIENT_W-1:0] client_id;
    logic [AMOUNT_W-1:0] amount;
    logic [AMOUNT_W-1:0] accumulated_orders;
    logic [MAX_W-1:0]    max_to_trade;
    logic                thenewmax;
    logic                order_accepted;
    logic                order_rejected;
    logic                busy;

    modport master (
        output new_order, new_max, client_id, amount,
        input  accumulated_orders, max_to_trade, thenewmax, order_accepted, order_rejected, busy
    );

    modport slave (
        input  new_order, new_max, client_id, amount,
        output accumulated_orders, max_to_trade, thenewmax, order_accepted, order_rejected, busy
    );

endinterface

// File: rtl/upstream_order_processor_rise_detect.sv
// Single-bit 0->1 detector: registered history, combinational one-cycle pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic hist_q;

    // History clears to 0, so a level already high at reset release counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 1'b0;
        else        hist_q <= d;
    end

    assign rise = d & ~hist_q;

endmodule

// File: rtl/upstream_order_processor.sv
// Order responder: per-client running totals, global traded total gated by a trading cap,
// with a one-deep pending slot for orders arriving while the FSM is busy.
module upstream_order_processor
    import upstream_pkg::*;
#(
    parameter int          MAX_SHIFT = 8,
    parameter logic [31:0] RESET_MAX = 32'h0000FFFF
) (
    input  logic clk,
    input  logic rst_n,
    upstream_order_processor_if.slave up
);

    logic order_rise, max_rise;

    rise_detect u_order_rise (.clk(clk), .rst_n(rst_n), .d(up.new_order), .rise(order_rise));
    rise_detect u_max_rise   (.clk(clk), .rst_n(rst_n), .d(up.new_max),   .rise(max_rise));

    up_state_t           state_q, state_d;
    logic                pend_q, pend_d;
    logic [CLIENT_W-1:0] pend_id_q, pend_id_d, cur_id_q, cur_id_d;
    logic [AMOUNT_W-1:0] pend_amt_q, pend_amt_d, cur_amt_q, cur_amt_d;
    logic [AMOUNT_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d;
    logic                ok_q, ok_d;
    logic [MAX_W-1:0]    total_q, total_d, max_q, max_d;
    logic                newmax_q, newmax_d, accepted_q, accepted_d, rejected_q, rejected_d;
    logic [AMOUNT_W-1:0] tbl_q [N_CLIENTS];
    logic                wr_en;
    logic [AMOUNT_W-1:0] wr_data;
    logic [MAX_W:0]      sum_chk;
    logic [MAX_W-1:0]    cap_val;

    // One extra bit so the cap comparison never wraps.
    assign sum_chk = {1'b0, total_q} + {{(MAX_W+1-AMOUNT_W){1'b0}}, cur_amt_q};
    assign cap_val = {{(MAX_W-AMOUNT_W){1'b0}}, up.amount} << MAX_SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (order_rise || pend_q) state_d = READ;
            READ:    state_d = CHECK;
            CHECK:   state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d     = pend_q;
        pend_id_d  = pend_id_q;
        pend_amt_d = pend_amt_q;
        cur_id_d   = cur_id_q;
        cur_amt_d  = cur_amt_q;
        acc_d      = acc_q;
        acc_out_d  = acc_out_q;
        ok_d       = ok_q;
        total_d    = total_q;
        max_d      = max_q;
        newmax_d   = 1'b0;
        accepted_d = 1'b0;
        rejected_d = 1'b0;
        wr_en      = 1'b0;
        wr_data    = sat16(acc_q, cur_amt_q);

        if (max_rise) begin
            max_d    = cap_val;
            newmax_d = 1'b1;
        end

        // The working order register must stay stable until COMMIT, so late edges park in pend.
        if (order_rise) begin
            if (state_q == IDLE) begin
                cur_id_d  = up.client_id;
                cur_amt_d = up.amount;
                pend_d    = 1'b0;
            end else begin
                pend_d     = 1'b1;
                pend_id_d  = up.client_id;
                pend_amt_d = up.amount;
            end
        end else if (state_q == IDLE && pend_q) begin
            cur_id_d  = pend_id_q;
            cur_amt_d = pend_amt_q;
            pend_d    = 1'b0;
        end

        case (state_q)
            READ:  acc_d = tbl_q[cur_id_q];
            CHECK: ok_d  = sum_chk <= {1'b0, max_q};
            COMMIT: begin
                if (ok_q) begin
                    total_d    = sum_chk[MAX_W] ? {MAX_W{1'b1}} : sum_chk[MAX_W-1:0];
                    wr_en      = 1'b1;
                    acc_out_d  = wr_data;
                    accepted_d = 1'b1;
                end else begin
                    acc_out_d  = acc_q;
                    rejected_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_id_q  <= '0;
            pend_amt_q <= '0;
            cur_id_q   <= '0;
            cur_amt_q  <= '0;
            acc_q      <= '0;
            acc_out_q  <= '0;
            ok_q       <= 1'b0;
            total_q    <= '0;
            max_q      <= RESET_MAX;
            newmax_q   <= 1'b0;
            accepted_q <= 1'b0;
            rejected_q <= 1'b0;
            for (int i = 0; i < N_CLIENTS; i++) tbl_q[i] <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_id_q  <= pend_id_d;
            pend_amt_q <= pend_amt_d;
            cur_id_q   <= cur_id_d;
            cur_amt_q  <= cur_amt_d;
            acc_q      <= acc_d;
            acc_out_q  <= acc_out_d;
            ok_q       <= ok_d;
            total_q    <= total_d;
            max_q      <= max_d;
            newmax_q   <= newmax_d;
            accepted_q <= accepted_d;
            rejected_q <= rejected_d;
            if (wr_en) tbl_q[cur_id_q] <= wr_data;
        end
    end

    assign up.accumulated_orders = acc_out_q;
    assign up.max_to_trade       = max_q;
    assign up.thenewmax          = newmax_q;
    assign up.order_accepted     = accepted_q;
    assign up.order_rejected     = rejected_q;
    assign up.busy               = (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_upstream_order_processor.sv
// Randomized and directed bench for upstream_order_processor against a transaction-level model.
module tb_upstream_order_processor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    upstream_order_processor_if up ();

    upstream_order_processor #(.MAX_SHIFT(8), .RESET_MAX(32'h0000FFFF)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .up   (up)
    );

    // Reference state: per-client totals, traded total and cap as plain numbers.
    int     m_tbl [32];
    longint m_total;
    longint m_cap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = 0;
        m_total = 0;
        m_cap   = 64'h0000FFFF;
    endtask

    // Applies one order to the model; returns accept flag and reported per-client total.
    task automatic model_order(input int id, input int amt, output bit ok, output int acc);
        ok = (m_total + amt) <= m_cap;
        if (ok) begin
            m_tbl[id] = (m_tbl[id] + amt > 65535) ? 65535 : m_tbl[id] + amt;
            m_total   = (m_total + amt > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_total + amt;
        end
        acc = m_tbl[id];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acc"},  {16'h0, up.accumulated_orders}, 32'h0);
        chk({tag, "_max"},  up.max_to_trade, 32'h0000FFFF);
        chk({tag, "_puls"}, {29'h0, up.thenewmax, up.order_accepted, up.order_rejected}, 32'h0);
        chk({tag, "_busy"}, {31'h0, up.busy}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        up.new_order = 1'b0;
        up.new_max   = 1'b0;
        #3;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc();
    endtask

    // One operation: order, cap update, or both in the same cycle; inputs held 'hold' cycles.
    task automatic do_op(input bit o, input bit m, input int id, input int amt, input int hold);
        bit ok;
        int exp_acc;
        int steps;
        ok = 1'b0;
        exp_acc = 0;
        if (m) m_cap = longint'(amt) << 8;
        if (o) model_order(id, amt, ok, exp_acc);
        up.new_order = o;
        up.new_max   = m;
        up.client_id = 5'(id);
        up.amount    = 16'(amt);
        steps = (hold + 1 > 6) ? hold + 1 : 6;
        for (int i = 1; i <= steps; i++) begin
            cyc();
            if (m && i == 1) begin
                chk("newmax_pulse", {31'h0, up.thenewmax}, 32'h1);
                chk("max_to_trade", up.max_to_trade, 32'(m_cap));
            end
            if (m && i >= 2) chk("newmax_once", {31'h0, up.thenewmax}, 32'h0);
            if (o && i == 1) chk("busy_set", {31'h0, up.busy}, 32'h1);
            if (o && i == 4) begin
                chk("accepted", {31'h0, up.order_accepted}, {31'h0, ok});
                chk("rejected", {31'h0, up.order_rejected}, {31'h0, ~ok});
                chk("acc_out", {16'h0, up.accumulated_orders}, 32'(exp_acc));
            end else if (i >= 2) begin
                chk("no_pulse", {30'h0, up.order_accepted, up.order_rejected}, 32'h0);
            end
            if (i == hold) begin
                up.new_order = 1'b0;
                up.new_max   = 1'b0;
            end
        end
        chk("idle_after", {31'h0, up.busy}, 32'h0);
    endtask

    initial begin
        bit ok_a, ok_b;
        int acc_a, acc_b;
        up.new_order = 1'b0;
        up.new_max   = 1'b0;
        up.client_id = '0;
        up.amount    = '0;
        model_reset();

        // Reset state and quiet idle
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_quiet", {29'h0, up.thenewmax, up.order_accepted, up.order_rejected}, 32'h0);
        end

        // Basic accumulation, long hold counted once
        do_op(1, 0, 3, 100, 1);
        do_op(1, 0, 3, 100, 20);

        // Cap update and rejection at the boundary
        do_op(0, 1, 0, 1, 2);
        do_op(1, 0, 4, 56, 1);
        do_op(1, 0, 4, 1, 1);

        // Simultaneous cap/order: old cap 0 would reject, new cap 0x1000 accepts
        do_reset();
        do_op(0, 1, 0, 0, 1);
        do_op(1, 1, 9, 16'h10, 1);

        // Per-client saturation and zero-amount order
        do_op(0, 1, 0, 16'hFFFF, 1);
        do_op(1, 0, 7, 16'hFFF0, 1);
        do_op(1, 0, 7, 16'h0020, 1);
        do_op(1, 0, 7, 0, 3);

        // Back-to-back: second edge two cycles later is served from pending
        model_order(12, 300, ok_a, acc_a);
        model_order(13, 400, ok_b, acc_b);
        up.client_id = 5'd12; up.amount = 16'd300; up.new_order = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (i == 4) begin
                chk("b2b_acc_a", {31'h0, up.order_accepted}, {31'h0, ok_a});
                chk("b2b_val_a", {16'h0, up.accumulated_orders}, 32'(acc_a));
            end else if (i == 8) begin
                chk("b2b_acc_b", {31'h0, up.order_accepted}, {31'h0, ok_b});
                chk("b2b_val_b", {16'h0, up.accumulated_orders}, 32'(acc_b));
            end else begin
                chk("b2b_gap", {30'h0, up.order_accepted, up.order_rejected}, 32'h0);
            end
            if (i == 6) chk("b2b_busy", {31'h0, up.busy}, 32'h1);
            if (i == 1 || i == 3) up.new_order = 1'b0;
            if (i == 2) begin
                up.client_id = 5'd13; up.amount = 16'd400; up.new_order = 1'b1;
            end
        end

        // Reset during CHECK aborts the order with no pulse; table is cleared
        up.client_id = 5'd7; up.amount = 16'd5; up.new_order = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        up.new_order = 1'b0;
        #2;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("midrst_quiet", {30'h0, up.order_accepted, up.order_rejected}, 32'h0);
        end
        do_op(1, 0, 7, 5, 1);

        // Randomized mix against the model
        for (int n = 0; n < 150; n++) begin
            int r, id, amt, hold;
            r    = $urandom_range(0, 9);
            id   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            amt  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 65535);
            hold = $urandom_range(1, 6);
            if (r < 7)       do_op(1, 0, id, amt, hold);
            else if (r == 7) do_op(0, 1, id, amt, hold);
            else             do_op(1, 1, id, amt, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
